// File: rtl/pc_stack_pkg.sv
// Shared encodings for the program counter / return stack: stack ops, nibble sources,
// and the subcycle numbering used by the address drive.
package pc_stack_pkg;

  typedef enum logic [1:0] {
    StackNone = 2'd0,
    StackPush = 2'd1,
    StackPop  = 2'd2,
    StackRsvd = 2'd3
  } stack_op_e;

  typedef enum logic [1:0] {
    PcFromData = 2'd0,
    PcFromInst = 2'd1,
    PcFromReg  = 2'd2,
    PcFromNone = 2'd3
  } pc_src_e;

  localparam int unsigned PcWidth = 12;
  localparam logic [2:0] LastFetchCycle = 3'd2;
  localparam logic [2:0] LastCycle = 3'd7;

  function automatic logic [3:0] pc_nibble(input logic [PcWidth-1:0] pc, input logic [2:0] cyc);
    logic [3:0] nib;
    case (cyc)
      3'd0:    nib = pc[3:0];
      3'd1:    nib = pc[7:4];
      3'd2:    nib = pc[11:8];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Control and bus signals between cpu_control (master) and pc_stack (slave).
interface pc_stack_if;
  import pc_stack_pkg::*;

  logic [2:0]         cycle;
  logic [3:0]         data_in;
  logic [3:0]         inst_operand;
  logic [3:0]         reg_value;
  logic [1:0]         pc_next_sel;
  logic [2:0]         pc_write_enable;
  logic [1:0]         pc_control;
  logic               reg_out_enable;
  logic [3:0]         addr_out;
  logic               addr_out_en;
  logic [PcWidth-1:0] pc;

  modport master (
    output cycle, data_in, inst_operand, reg_value, pc_next_sel, pc_write_enable,
    output pc_control, reg_out_enable,
    input  addr_out, addr_out_en, pc
  );

  modport slave (
    input  cycle, data_in, inst_operand, reg_value, pc_next_sel, pc_write_enable,
    input  pc_control, reg_out_enable,
    output addr_out, addr_out_en, pc
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with a circular return stack; the active PC is stack[ptr] and is emitted
// on the 4-bit bus one nibble per subcycle during cycles 0-2.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic      clock,
  input logic      reset_n,
  pc_stack_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  typedef logic [PtrW-1:0] ptr_t;

  logic [PcWidth-1:0] stack_q [DEPTH];
  ptr_t               ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic               indirect_q, indirect_d;
  logic [PcWidth-1:0] cur_pc, base_pc, next_pc;
  logic [3:0]         src_nib;
  logic               do_inc, wr_ok, push, pop;

  always_comb begin
    cur_pc  = stack_q[ptr_q];
    // An indirect (FIN) data fetch borrows the address bus and must not advance the PC.
    do_inc  = (bus.cycle == LastFetchCycle) && !indirect_q && !bus.reg_out_enable;
    base_pc = do_inc ? cur_pc + 12'd1 : cur_pc;

    src_nib = bus.data_in;
    wr_ok   = 1'b1;
    case (bus.pc_next_sel)
      PcFromData: src_nib = bus.data_in;
      PcFromInst: src_nib = bus.inst_operand;
      PcFromReg:  src_nib = bus.reg_value;
      default:    wr_ok = 1'b0;
    endcase

    next_pc = base_pc;
    for (int i = 0; i < 3; i++) begin
      if (wr_ok && bus.pc_write_enable[i]) next_pc[4*i +: 4] = src_nib;
    end

    push    = (bus.pc_control == StackPush);
    pop     = (bus.pc_control == StackPop);
    ptr_inc = ptr_q + ptr_t'(1);
    ptr_dec = ptr_q - ptr_t'(1);
    ptr_d   = push ? ptr_inc : (pop ? ptr_dec : ptr_q);

    indirect_d = indirect_q;
    if (bus.cycle == LastCycle) begin
      indirect_d = 1'b0;
    end else if (bus.reg_out_enable && (bus.cycle <= 3'd1)) begin
      indirect_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      ptr_q      <= '0;
      indirect_q <= 1'b0;
    end else begin
      // Pop leaves the pre-pop slot holding next_pc; push copies it as the return address.
      stack_q[ptr_q] <= next_pc;
      if (push) stack_q[ptr_inc] <= next_pc;
      ptr_q      <= ptr_d;
      indirect_q <= indirect_d;
    end
  end

  assign bus.addr_out_en = reset_n && (bus.cycle <= LastFetchCycle) && !bus.reg_out_enable;
  assign bus.addr_out    = bus.addr_out_en ? pc_nibble(cur_pc, bus.cycle) : 4'h0;
  assign bus.pc          = cur_pc;

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: scenario tasks act as cpu_control, a scoreboard checks every bus nibble.
module tb_pc_stack;
  import pc_stack_pkg::*;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  typedef struct packed {
    logic       en;
    logic [3:0] addr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [11:0] fetch_pc;

  pc_stack_if bus ();

  pc_stack #(.DEPTH(4)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Scoreboard: one expectation per driven subcycle, compared mid-cycle.
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if ({bus.addr_out_en, bus.addr_out} !== {mon_e.en, mon_e.addr}) begin
        failures++;
        $display("FAIL addr_bus cyc=%0d fetch_pc=%h got en=%b addr=%h want en=%b addr=%h",
                 bus.cycle, fetch_pc, bus.addr_out_en, bus.addr_out, mon_e.en, mon_e.addr);
      end
    end
  end

  task automatic tick(input logic [2:0] cyc, input logic [2:0] we, input logic [1:0] sel,
                      input logic [3:0] nib, input logic [1:0] ctl, input logic roe);
    exp_t e;
    bus.cycle           = cyc;
    bus.pc_write_enable = we;
    bus.pc_next_sel     = sel;
    bus.data_in         = (sel == 2'd0) ? nib : ~nib;
    bus.inst_operand    = (sel == 2'd1) ? nib : ~nib;
    bus.reg_value       = (sel == 2'd2) ? nib : ~nib;
    bus.pc_control      = ctl;
    bus.reg_out_enable  = roe;
    e.en   = (cyc <= 3'd2) && !roe;
    e.addr = !e.en ? 4'h0 :
             (cyc == 3'd0) ? fetch_pc[3:0] : (cyc == 3'd1) ? fetch_pc[7:4] : fetch_pc[11:8];
    sb_q.push_back(e);
    @(posedge clock);
    #2;
  endtask

  task automatic fetch(input logic [11:0] at, input logic [1:0] ctl2);
    fetch_pc = at;
    tick(3'd0, 3'b000, 2'd3, 4'h0, StackNone, 1'b0);
    tick(3'd1, 3'b000, 2'd3, 4'h0, StackNone, 1'b0);
    tick(3'd2, 3'b000, 2'd3, 4'h0, ctl2, 1'b0);
  endtask

  task automatic idle_tail();
    for (int c = 3; c < 8; c++) tick(3'(c), 3'b000, 2'd3, 4'h0, StackNone, 1'b0);
  endtask

  task automatic jump_tail(input logic [11:0] addr);
    tick(3'd3, 3'b100, 2'd1, addr[11:8], StackNone, 1'b0);
    tick(3'd4, 3'b010, 2'd0, addr[7:4], StackNone, 1'b0);
    tick(3'd5, 3'b001, 2'd2, addr[3:0], StackNone, 1'b0);
    tick(3'd6, 3'b000, 2'd3, 4'h0, StackNone, 1'b0);
    tick(3'd7, 3'b000, 2'd3, 4'h0, StackNone, 1'b0);
  endtask

  task automatic test_reset();
    reset_n                = 1'b0;
    bus.cycle              = 3'd0;
    bus.pc_write_enable    = 3'b000;
    bus.pc_next_sel        = 2'd3;
    bus.data_in            = 4'h0;
    bus.inst_operand       = 4'h0;
    bus.reg_value          = 4'h0;
    bus.pc_control         = StackNone;
    bus.reg_out_enable     = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    checks++;
    if (bus.pc !== 12'h000) begin
      failures++;
      $display("FAIL reset_pc got=%h want=000", bus.pc);
    end
    checks++;
    if ({bus.addr_out_en, bus.addr_out} !== 5'b0) begin
      failures++;
      $display("FAIL reset_bus got en=%b addr=%h want en=0 addr=0", bus.addr_out_en, bus.addr_out);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      fetch(12'(i), StackNone);
      checks++;
      if (bus.pc !== 12'(i + 1)) begin
        failures++;
        $display("FAIL seq_inc got=%h want=%h", bus.pc, 12'(i + 1));
      end
      idle_tail();
    end
  endtask

  task automatic test_jun();
    fetch(12'h003, StackNone);
    tick(3'd3, 3'b010, 2'd0, 4'hA, StackNone, 1'b0);
    tick(3'd4, 3'b001, 2'd0, 4'h5, StackNone, 1'b0);
    tick(3'd5, 3'b100, 2'd1, 4'h3, StackNone, 1'b0);
    tick(3'd6, 3'b000, 2'd3, 4'h0, StackNone, 1'b0);
    tick(3'd7, 3'b000, 2'd3, 4'h0, StackNone, 1'b0);
    checks++;
    if (bus.pc !== 12'h3A5) begin
      failures++;
      $display("FAIL jun_target got=%h want=3a5", bus.pc);
    end
    fetch(12'h3A5, StackNone);
    checks++;
    if (bus.pc !== 12'h3A6) begin
      failures++;
      $display("FAIL jun_next got=%h want=3a6", bus.pc);
    end
    idle_tail();
  endtask

  task automatic test_jms();
    fetch(12'h3A6, StackNone);
    jump_tail(12'h120);
    fetch(12'h120, StackPush);
    checks++;
    if (bus.pc !== 12'h121 || dut.ptr_q !== 2'd1) begin
      failures++;
      $display("FAIL jms_push got pc=%h ptr=%0d want pc=121 ptr=1", bus.pc, dut.ptr_q);
    end
    jump_tail(12'h7BC);
    checks++;
    if (bus.pc !== 12'h7BC || dut.stack_q[0] !== 12'h121) begin
      failures++;
      $display("FAIL jms_target got pc=%h ret=%h want pc=7bc ret=121", bus.pc, dut.stack_q[0]);
    end
    fetch(12'h7BC, StackPop);
    checks++;
    if (bus.pc !== 12'h121 || dut.ptr_q !== 2'd0) begin
      failures++;
      $display("FAIL jms_pop got pc=%h ptr=%0d want pc=121 ptr=0", bus.pc, dut.ptr_q);
    end
    idle_tail();
    fetch(12'h121, StackNone);
    checks++;
    if (bus.pc !== 12'h122) begin
      failures++;
      $display("FAIL jms_return_fetch got=%h want=122", bus.pc);
    end
    idle_tail();
  endtask

  task automatic test_overflow();
    logic [11:0] at;
    logic [11:0] rets [4];
    rets = '{12'h301, 12'h201, 12'h101, 12'h401};
    fetch(12'h122, StackNone);
    jump_tail(12'h010);
    at = 12'h010;
    for (int k = 1; k <= 4; k++) begin
      fetch(at, StackPush);
      jump_tail(12'(k << 8));
      at = 12'(k << 8);
    end
    checks++;
    if (bus.pc !== 12'h400 || dut.ptr_q !== 2'd0) begin
      failures++;
      $display("FAIL ovf_push got pc=%h ptr=%0d want pc=400 ptr=0", bus.pc, dut.ptr_q);
    end
    for (int k = 0; k < 4; k++) begin
      fetch(at, StackPop);
      checks++;
      if (bus.pc !== rets[k] || $isunknown(bus.pc)) begin
        failures++;
        $display("FAIL ovf_pop%0d got=%h want=%h", k, bus.pc, rets[k]);
      end
      at = rets[k];
      idle_tail();
    end
  endtask

  task automatic test_fin();
    fetch(12'h401, StackNone);
    idle_tail();
    fetch_pc = 12'h402;
    tick(3'd0, 3'b000, 2'd3, 4'h0, StackNone, 1'b1);
    tick(3'd1, 3'b000, 2'd3, 4'h0, StackNone, 1'b1);
    tick(3'd2, 3'b000, 2'd3, 4'h0, StackNone, 1'b0);
    checks++;
    if (bus.pc !== 12'h402) begin
      failures++;
      $display("FAIL fin_no_inc got=%h want=402", bus.pc);
    end
    idle_tail();
    fetch(12'h402, StackNone);
    checks++;
    if (bus.pc !== 12'h403) begin
      failures++;
      $display("FAIL fin_after got=%h want=403", bus.pc);
    end
    idle_tail();
  endtask

  task automatic test_wrap();
    fetch(12'h403, StackNone);
    jump_tail(12'hFFF);
    fetch(12'hFFF, StackNone);
    checks++;
    if (bus.pc !== 12'h000) begin
      failures++;
      $display("FAIL wrap got=%h want=000", bus.pc);
    end
    idle_tail();
  endtask

  task automatic test_same_edge();
    fetch(12'h000, StackNone);
    jump_tail(12'h0FF);
    fetch_pc = 12'h0FF;
    tick(3'd0, 3'b000, 2'd3, 4'h0, StackNone, 1'b0);
    tick(3'd1, 3'b000, 2'd3, 4'h0, StackNone, 1'b0);
    tick(3'd2, 3'b001, 2'd0, 4'h7, StackNone, 1'b0);
    checks++;
    if (bus.pc !== 12'h107) begin
      failures++;
      $display("FAIL inc_write_override got=%h want=107", bus.pc);
    end
    tick(3'd3, 3'b011, 2'd1, 4'h9, StackNone, 1'b0);
    checks++;
    if (bus.pc !== 12'h199) begin
      failures++;
      $display("FAIL multi_enable got=%h want=199", bus.pc);
    end
    tick(3'd4, 3'b111, 2'd3, 4'h5, StackRsvd, 1'b0);
    checks++;
    if (bus.pc !== 12'h199 || dut.ptr_q !== 2'd0) begin
      failures++;
      $display("FAIL sel3_nop got pc=%h ptr=%0d want pc=199 ptr=0", bus.pc, dut.ptr_q);
    end
    for (int c = 5; c < 8; c++) tick(3'(c), 3'b000, 2'd3, 4'h0, StackNone, 1'b0);
  endtask

  task automatic test_reset_mid();
    fetch(12'h199, StackPush);
    tick(3'd3, 3'b100, 2'd1, 4'hC, StackNone, 1'b0);
    checks++;
    if (bus.pc !== 12'hC9A) begin
      failures++;
      $display("FAIL mid_jms_write got=%h want=c9a", bus.pc);
    end
    bus.cycle           = 3'd4;
    bus.pc_write_enable = 3'b010;
    bus.pc_next_sel     = 2'd0;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.pc !== 12'h000 || dut.ptr_q !== 2'd0 || bus.addr_out_en !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got pc=%h ptr=%0d en=%b want pc=000 ptr=0 en=0",
               bus.pc, dut.ptr_q, bus.addr_out_en);
    end
    @(posedge clock);
    #2 reset_n = 1'b1;
    fetch(12'h000, StackNone);
    checks++;
    if (bus.pc !== 12'h001) begin
      failures++;
      $display("FAIL post_reset got=%h want=001", bus.pc);
    end
    idle_tail();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    fetch_pc = 12'h000;
    test_reset();
    test_sequential();
    test_jun();
    test_jms();
    test_overflow();
    test_fin();
    test_wrap();
    test_same_edge();
    test_reset_mid();
    @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
